// File: rtl/onehot_seq_pkg.sv
// Shared widths, step-decision encoding and the index-to-one-hot helper
// for the digit sequencer.
package onehot_seq_pkg;

    localparam int DIGIT_W  = 3;
    localparam int ONEHOT_W = 8;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_INC  = 2'd1,
        STEP_DEC  = 2'd2
    } step_e;

    function automatic logic [ONEHOT_W-1:0] idx_to_onehot(input logic [DIGIT_W-1:0] idx);
        logic [ONEHOT_W-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/onehot_digit_sequencer_debounce.sv
// Two-flop synchronizer, consecutive-cycle debouncer and rising-edge detect
// for one raw push-button; press_o is a one-cycle pulse per accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q,      stable_d;
    logic             stable_prev_q;
    logic [CNT_W-1:0] cnt_q,         cnt_d;

    // Any cycle where the synchronized level agrees with the accepted level
    // restarts the qualification window, so short glitches never accumulate.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= btn_raw_i;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
        end
    end

    assign press_o = stable_q & ~stable_prev_q;

endmodule

// File: rtl/onehot_digit_sequencer.sv
// Digit index sequencer: debounced up/down buttons plus an auto-advance
// prescaler drive a 3-bit index and its registered one-hot image.
module onehot_digit_sequencer
    import onehot_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int AUTO_PERIOD     = 1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                auto_en,
    output logic [ONEHOT_W-1:0] digit_onehot,
    output logic [DIGIT_W-1:0]  digit_idx,
    output logic                step_pulse
);

    localparam int PRESC_W = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(AUTO_PERIOD - 1);

    logic                up_evt;
    logic                down_evt;
    logic                auto_evt;
    step_e               step_sel;

    logic [PRESC_W-1:0]  presc_q,  presc_d;
    logic [DIGIT_W-1:0]  idx_q,    idx_d;
    logic [ONEHOT_W-1:0] onehot_q, onehot_d;
    logic                step_q,   step_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk       (clk),
        .rst       (rst),
        .btn_raw_i (btn_up),
        .press_o   (up_evt)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .clk       (clk),
        .rst       (rst),
        .btn_raw_i (btn_down),
        .press_o   (down_evt)
    );

    assign auto_evt = auto_en && (presc_q == PRESC_LAST);

    // The terminal count always wraps the prescaler, so an auto event that
    // loses to a button event still restarts the period from zero.
    always_comb begin
        presc_d = presc_q + 1'b1;
        if (!auto_en || auto_evt) begin
            presc_d = '0;
        end
    end

    always_comb begin
        step_sel = STEP_NONE;
        if (up_evt && down_evt) begin
            step_sel = STEP_NONE;
        end else if (up_evt) begin
            step_sel = STEP_INC;
        end else if (down_evt) begin
            step_sel = STEP_DEC;
        end else if (auto_evt) begin
            step_sel = STEP_INC;
        end
    end

    always_comb begin
        idx_d  = idx_q;
        step_d = 1'b0;
        unique case (step_sel)
            STEP_INC: begin
                idx_d  = idx_q + 1'b1;
                step_d = 1'b1;
            end
            STEP_DEC: begin
                idx_d  = idx_q - 1'b1;
                step_d = 1'b1;
            end
            default: begin
                idx_d  = idx_q;
                step_d = 1'b0;
            end
        endcase
        onehot_d = idx_to_onehot(idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q  <= '0;
            idx_q    <= '0;
            onehot_q <= idx_to_onehot('0);
            step_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            step_q   <= step_d;
        end
    end

    assign digit_idx    = idx_q;
    assign digit_onehot = onehot_q;
    assign step_pulse   = step_q;

endmodule

// File: tb/tb_onehot_digit_sequencer.sv
// Directed bench for onehot_digit_sequencer with DEBOUNCE_CYCLES=4 and
// AUTO_PERIOD=5; expected indices and one-hot codes are hand-derived.
module tb_onehot_digit_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic       auto_en;
    logic [7:0] digit_onehot;
    logic [2:0] digit_idx;
    logic       step_pulse;

    int nCompared   = 0;
    int nMismatched = 0;
    int pulseCount  = 0;

    onehot_digit_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .AUTO_PERIOD     (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .auto_en      (auto_en),
        .digit_onehot (digit_onehot),
        .digit_idx    (digit_idx),
        .step_pulse   (step_pulse)
    );

    always #5 clk = ~clk;

    // Advance n clock edges, sampling 1 time unit after each edge.
    task automatic stepCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (step_pulse === 1'b1) pulseCount++;
        end
    endtask

    task automatic pressButton(input bit up);
        if (up) btn_up = 1'b1; else btn_down = 1'b1;
        stepCycles(20);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        stepCycles(10);
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; auto_en = 1'b0;
        stepCycles(3);
        nCompared++;
        if (digit_idx !== 3'd0) begin
            nMismatched++; $display("[TB] FAIL reset_idx: got %0d expected 0", digit_idx);
        end
        nCompared++;
        if (digit_onehot !== 8'h01) begin
            nMismatched++; $display("[TB] FAIL reset_onehot: got %h expected 01", digit_onehot);
        end
        nCompared++;
        if (step_pulse !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL reset_pulse: got %b expected 0", step_pulse);
        end
        rst = 1'b0;
        stepCycles(2);
    endtask

    task automatic test_up_press();
        logic [7:0] expOh;
        pulseCount = 0;
        btn_up = 1'b1;
        stepCycles(6);
        nCompared++;
        if (digit_idx !== 3'd0) begin
            nMismatched++; $display("[TB] FAIL up_early: got %0d expected 0 at edge k+5", digit_idx);
        end
        stepCycles(1);
        nCompared++;
        if (digit_idx !== 3'd1 || digit_onehot !== 8'h02) begin
            nMismatched++;
            $display("[TB] FAIL up_latency: got idx %0d oh %h expected idx 1 oh 02 at edge k+6", digit_idx, digit_onehot);
        end
        nCompared++;
        if (step_pulse !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL up_pulse: got %b expected 1", step_pulse);
        end
        stepCycles(13);
        btn_up = 1'b0;
        stepCycles(10);
        nCompared++;
        if (pulseCount !== 1) begin
            nMismatched++; $display("[TB] FAIL up_single_step: got %0d pulses expected 1", pulseCount);
        end
        for (int p = 2; p <= 8; p++) begin
            pulseCount = 0;
            pressButton(1'b1);
            expOh = 8'h01 << (p % 8);
            nCompared++;
            if (digit_idx !== 3'(p % 8) || digit_onehot !== expOh) begin
                nMismatched++;
                $display("[TB] FAIL up_repeat_%0d: got idx %0d oh %h expected idx %0d oh %h", p, digit_idx, digit_onehot, p % 8, expOh);
            end
            nCompared++;
            if (pulseCount !== 1) begin
                nMismatched++; $display("[TB] FAIL up_repeat_pulses_%0d: got %0d expected 1", p, pulseCount);
            end
        end
    endtask

    task automatic test_bounce();
        pulseCount = 0;
        for (int i = 0; i < 6; i++) begin
            btn_up = (i % 2 == 0);
            stepCycles(2);
        end
        btn_up = 1'b0;
        stepCycles(10);
        nCompared++;
        if (pulseCount !== 0) begin
            nMismatched++; $display("[TB] FAIL bounce_pulses: got %0d expected 0", pulseCount);
        end
        nCompared++;
        if (digit_idx !== 3'd0) begin
            nMismatched++; $display("[TB] FAIL bounce_idx: got %0d expected 0", digit_idx);
        end
    endtask

    task automatic test_down_wrap();
        pulseCount = 0;
        pressButton(1'b0);
        nCompared++;
        if (digit_idx !== 3'd7 || digit_onehot !== 8'h80) begin
            nMismatched++;
            $display("[TB] FAIL down_wrap: got idx %0d oh %h expected idx 7 oh 80", digit_idx, digit_onehot);
        end
        nCompared++;
        if (pulseCount !== 1) begin
            nMismatched++; $display("[TB] FAIL down_pulses: got %0d expected 1", pulseCount);
        end
    endtask

    task automatic test_simultaneous();
        pulseCount = 0;
        btn_up = 1'b1; btn_down = 1'b1;
        stepCycles(20);
        btn_up = 1'b0; btn_down = 1'b0;
        stepCycles(10);
        nCompared++;
        if (pulseCount !== 0 || digit_idx !== 3'd7) begin
            nMismatched++;
            $display("[TB] FAIL both_buttons: got %0d pulses idx %0d expected 0 pulses idx 7", pulseCount, digit_idx);
        end
    endtask

    task automatic test_auto_collision();
        pulseCount = 0;
        btn_up = 1'b1;
        stepCycles(2);
        auto_en = 1'b1;
        stepCycles(4);
        nCompared++;
        if (pulseCount !== 0 || digit_idx !== 3'd7) begin
            nMismatched++;
            $display("[TB] FAIL collide_early: got %0d pulses idx %0d expected 0 pulses idx 7", pulseCount, digit_idx);
        end
        stepCycles(1);
        nCompared++;
        if (digit_idx !== 3'd0 || digit_onehot !== 8'h01 || step_pulse !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL collide_step: got idx %0d oh %h pulse %b expected idx 0 oh 01 pulse 1", digit_idx, digit_onehot, step_pulse);
        end
        stepCycles(4);
        nCompared++;
        if (pulseCount !== 1 || digit_idx !== 3'd0) begin
            nMismatched++;
            $display("[TB] FAIL collide_gap: got %0d pulses idx %0d expected 1 pulse idx 0", pulseCount, digit_idx);
        end
        stepCycles(1);
        nCompared++;
        if (digit_idx !== 3'd1 || step_pulse !== 1'b1 || pulseCount !== 2) begin
            nMismatched++;
            $display("[TB] FAIL collide_next_auto: got idx %0d pulse %b count %0d expected idx 1 pulse 1 count 2", digit_idx, step_pulse, pulseCount);
        end
        auto_en = 1'b0;
        btn_up  = 1'b0;
        stepCycles(10);
    endtask

    task automatic test_auto_and_reset();
        pulseCount = 0;
        pressButton(1'b1);
        nCompared++;
        if (digit_idx !== 3'd2) begin
            nMismatched++; $display("[TB] FAIL auto_start_idx: got %0d expected 2", digit_idx);
        end
        pulseCount = 0;
        auto_en = 1'b1;
        stepCycles(4);
        nCompared++;
        if (digit_idx !== 3'd2) begin
            nMismatched++; $display("[TB] FAIL auto_before: got %0d expected 2", digit_idx);
        end
        stepCycles(1);
        nCompared++;
        if (digit_idx !== 3'd3 || step_pulse !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL auto_step1: got idx %0d pulse %b expected 3 1", digit_idx, step_pulse);
        end
        stepCycles(5);
        nCompared++;
        if (digit_idx !== 3'd4 || digit_onehot !== 8'h10) begin
            nMismatched++; $display("[TB] FAIL auto_step2: got idx %0d oh %h expected 4 10", digit_idx, digit_onehot);
        end
        stepCycles(5);
        nCompared++;
        if (digit_idx !== 3'd5 || pulseCount !== 3) begin
            nMismatched++; $display("[TB] FAIL auto_step3: got idx %0d pulses %0d expected 5 3", digit_idx, pulseCount);
        end
        btn_up = 1'b1;
        stepCycles(3);
        rst = 1'b1;
        stepCycles(1);
        nCompared++;
        if (digit_idx !== 3'd0 || digit_onehot !== 8'h01 || step_pulse !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL midrun_reset: got idx %0d oh %h pulse %b expected 0 01 0", digit_idx, digit_onehot, step_pulse);
        end
        btn_up  = 1'b0;
        auto_en = 1'b0;
        stepCycles(2);
        rst = 1'b0;
        pulseCount = 0;
        stepCycles(15);
        nCompared++;
        if (pulseCount !== 0 || digit_idx !== 3'd0) begin
            nMismatched++;
            $display("[TB] FAIL post_reset_quiet: got %0d pulses idx %0d expected 0 0", pulseCount, digit_idx);
        end
    endtask

    initial begin
        test_reset();
        test_up_press();
        test_bounce();
        test_down_wrap();
        test_simultaneous();
        test_auto_collision();
        test_auto_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/onehot_digit_sequencer.md
# onehot_digit_sequencer

Sequential front end for the one-hot-to-segment encoder. It debounces two raw push-buttons and can also self-advance from a prescaler. It keeps a 3-bit digit index in the range 0..7 and drives that index as an 8-bit one-hot code. The one-hot code connects directly to the encoder's 8-bit one-hot input.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 16: number of consecutive synchronized cycles at a new level before a button is accepted; legal range ≥2.
- AUTO_PERIOD, default 1_000_000: number of clock cycles between auto-advance steps; legal range ≥2.

Ports:
- clk  input  1  single clock for the whole block.
- rst  input  1  synchronous, active-high reset.
- btn_up  input  1  raw, asynchronous "next digit" button.
- btn_down  input  1  raw, asynchronous "previous digit" button.
- auto_en  input  1  enables auto-advance when high; sampled synchronously.
- digit_onehot  output  8  equals 1 << digit_idx; feeds the encoder input.
- digit_idx  output  3  current digit index.
- step_pulse  output  1  high for one cycle each time digit_idx changes.

## Operation
- Each button passes through its own 2-flop synchronizer and then a debouncer.
- Debouncer behaviour:
  - The counter clears whenever the synchronized value equals the stable value.
  - The counter increments while the two differ.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, the stable value toggles and the counter clears.
- A press event is the rising edge of a stable value; it is one cycle wide. Releases generate no event.
- Auto prescaler:
  - Counts 0..AUTO_PERIOD-1 while auto_en=1.
  - Its terminal count produces an auto event.
  - auto_en=0 holds the prescaler at 0.
- Priority rules, evaluated per cycle:
  - Up and down events in the same cycle: no change, no step_pulse.
  - A single button event wins over an auto event in the same cycle. The auto event is dropped and the prescaler restarts at 0.
  - Up event or auto event: idx+1 mod 8, so 7 wraps to 0.
  - Down event: idx-1 mod 8, so 0 wraps to 7.
- digit_onehot is registered and always has exactly one bit set.
- Reset values: digit_idx=0, digit_onehot=8'b0000_0001, step_pulse=0, all stable button values=0, all counters=0.

## Timing
- Let a button be high before clock edge k and stay high.
  - sync2 sees the new level after edge k+1.
  - The stable value rises at edge k+DEBOUNCE_CYCLES+1.
  - digit_idx, digit_onehot and step_pulse update at edge k+DEBOUNCE_CYCLES+2.
- Glitches shorter than DEBOUNCE_CYCLES synchronized cycles produce no event.
- Holding a button produces exactly one step; there is no auto-repeat.
- With auto_en held high from edge j, auto steps occur at edges j+AUTO_PERIOD, j+2·AUTO_PERIOD, and so on.
- step_pulse is high during the cycle in which the new digit_idx is first visible.
- When rst is asserted in a cycle, every output takes its reset value at that edge, overriding any pending event.
- After rst is released, a button already held counts as a fresh press: the stable value is 0 after reset, so a held button generates one event after the full debounce latency.

## Structure
- Package onehot_seq_pkg holds:
  - DIGIT_W=3 and ONEHOT_W=8.
  - The function idx_to_onehot(idx).
- Sub-module btn_debounce contains the synchronizer, the debounce counter and the rising-edge detect.
  - It is instantiated twice, once per button.
  - It takes DEBOUNCE_CYCLES as a parameter.
- The top level contains the prescaler, the priority logic and the index/one-hot registers.

## Test plan
All directed scenarios use DEBOUNCE_CYCLES=4 and AUTO_PERIOD=5.

1. Reset: hold rst for 3 cycles. Require digit_idx=0, digit_onehot=8'h01 and step_pulse=0.
2. Clean up-press: drive btn_up high at edge k and hold it for 20 cycles.
   - Require digit_idx=1 and digit_onehot=8'h02 at edge k+6.
   - Require exactly one step_pulse.
   - Repeat the press 7 more times. Require wrap-around to idx 0, digit_onehot=8'h01.
3. Bounce: toggle btn_up every 2 cycles for 12 cycles, then hold it low. Require no step_pulse and digit_idx unchanged.
4. Down wrap: from idx=0, apply one clean btn_down press. Require digit_idx=7 and digit_onehot=8'h80.
5. Simultaneous events:
   - Release both buttons at the same edge, then press both at the same edge. Require no step_pulse and no index change.
   - Separately, align an up event with the prescaler terminal count. Require exactly one increment, and the next auto step 5 cycles later.
6. Auto mode and reset mid-operation:
   - Set auto_en=1 from idx=2. Require idx 3, 4, 5 at 5-cycle spacing.
   - Assert rst with a debounce count in progress. Require idx=0 immediately and no late event after rst is released with the buttons low.
